color_fsm_commander: RTL

//  Command-side master for the two-state Color FSM, whose encoding is

---
 rtl/color_fsm_commander.sv | 113 +++++++++++
 1 files changed

// File: rtl/color_fsm_commander.sv
// rtl/color_fsm_commander.sv - command-side master steering the remote two-state Color FSM
module color_fsm_commander #(
  parameter int TIMEOUT   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_target,
  input  logic [1:0]           state_in,
  output logic [1:0]           cmd_out,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] toggle_count
);

  // Remote FSM state codes and command codes
  localparam logic [1:0] CODE_BLUE  = 2'h1;
  localparam logic [1:0] CODE_RED   = 2'h2;
  localparam logic [1:0] CMD_TOGGLE = 2'h1;
  localparam logic [1:0] CMD_NOP    = 2'h2;

  // Timer only needs to count up to TIMEOUT-1; keep at least one bit
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic                 target_q, target_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [1:0] req_code;
  logic [1:0] held_code;

  // Map a target colour bit onto the code the remote FSM reports for it
  assign req_code  = req_target ? CODE_RED : CODE_BLUE;
  assign held_code = target_q   ? CODE_RED : CODE_BLUE;

  // State, captured target, wait timer and toggle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= 1'b0;
      timer_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic; at most one toggle per request, then a bounded wait
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    timer_d  = timer_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          if (state_in != CODE_BLUE && state_in != CODE_RED) begin
            state_d = S_ERROR;
          end else if (state_in == req_code) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        if (count_q != {CNT_WIDTH{1'b1}}) begin
          count_d = count_q + CNT_WIDTH'(1);
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (state_in == held_code) begin
          state_d = S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode straight from the registers
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    cmd_out      = (state_q == S_ISSUE) ? CMD_TOGGLE : CMD_NOP;
    done         = (state_q == S_DONE);
    error        = (state_q == S_ERROR);
    toggle_count = count_q;
  end

endmodule
